// File: rtl/priority_encoder_rr.sv
// Registered N-to-log2(N) priority encoder, fixed or round-robin, 1-cycle latency.
// No back-pressure: one decision per enabled edge, outputs hold while en=0.
module priority_encoder_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         rr_en,
    input  logic [N-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         multi
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_nxt;
    logic [W-1:0] fixed_idx;
    logic [W-1:0] rr_idx;
    logic [W-1:0] win;
    logic [W-1:0] iw;
    logic         rr_hit;
    logic         any_req;
    logic         many_req;
    int           j;

    always_comb begin
        fixed_idx = '0;
        rr_idx    = '0;
        rr_hit    = 1'b0;
        iw        = '0;
        j         = 0;

        // Ascending scan: the last hit is the highest set index.
        for (int i = 0; i < N; i++) begin
            iw = W'(i);
            if (din[iw]) begin
                fixed_idx = iw;
            end
        end

        // Walk ptr, ptr-1, ... wrapping modulo N so ptr never leaves 0..N-1.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) - k;
            if (j < 0) begin
                j = j + N;
            end
            iw = W'(j);
            if (!rr_hit && din[iw]) begin
                rr_hit = 1'b1;
                rr_idx = iw;
            end
        end

        any_req  = |din;
        many_req = ($countones(din) >= 2);
        win      = rr_en ? rr_idx : fixed_idx;

        if (!rr_en) begin
            ptr_nxt = LAST;
        end else if (!any_req) begin
            ptr_nxt = ptr;
        end else if (win == '0) begin
            ptr_nxt = LAST;
        end else begin
            ptr_nxt = win - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
            ptr   <= LAST;
        end else if (en) begin
            dout  <= any_req ? win : '0;
            valid <= any_req;
            multi <= many_req;
            ptr   <= ptr_nxt;
        end
    end
endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr (N=8): directed literal checks plus a randomized run
// compared every cycle against a behavioural model.
module tb_priority_encoder_rr;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         rr_en = 1'b0;
    logic [N-1:0] din = '0;
    logic [W-1:0] dout;
    logic         valid;
    logic         multi;

    int vectors = 0;
    int miscompares = 0;
    bit check_on = 1'b0;

    int m_dout = 0;
    int m_valid = 0;
    int m_multi = 0;
    int m_ptr = N - 1;

    priority_encoder_rr #(.N(N)) dut (
        .clk(clk), .rst(rst), .en(en), .rr_en(rr_en),
        .din(din), .dout(dout), .valid(valid), .multi(multi)
    );

    always #5 clk = ~clk;

    function automatic int popcount(input logic [N-1:0] d);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(d[i]);
        return c;
    endfunction

    // Winner by the rules: highest index in fixed mode, first hit scanning down from p in rr mode.
    function automatic int pick(input bit rr, input int p, input logic [N-1:0] d);
        if (!rr) begin
            for (int i = N - 1; i >= 0; i--) if (d[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (d[(p - k + N) % N]) return (p - k + N) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dout = 0; m_valid = 0; m_multi = 0; m_ptr = N - 1;
        end else if (en) begin
            int w;
            w = pick(rr_en, m_ptr, din);
            m_valid = (w >= 0) ? 1 : 0;
            m_dout  = (w >= 0) ? w : 0;
            m_multi = (popcount(din) >= 2) ? 1 : 0;
            if (!rr_en) m_ptr = N - 1;
            else if (w >= 0) m_ptr = (w + N - 1) % N;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            chk("model_dout", int'(dout), m_dout);
            chk("model_valid", int'(valid), m_valid);
            chk("model_multi", int'(multi), m_multi);
        end
    end

    task automatic apply(input logic e, input logic r, input logic [N-1:0] d);
        en = e; rr_en = r; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string name, input int d, input int v, input int m);
        chk({name, "_dout"}, int'(dout), d);
        chk({name, "_valid"}, int'(valid), v);
        chk({name, "_multi"}, int'(multi), m);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    int seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    logic [N-1:0] one;

    initial begin
        rst = 1'b1;
        @(posedge clk); #1;
        expect3("reset", 0, 0, 0);
        rst = 1'b0;
        check_on = 1'b1;

        // Asynchronous reset between edges.
        apply(1, 0, 8'h20);
        expect3("pre_rst", 5, 1, 0);
        #2 rst = 1'b1;
        #1 expect3("async_rst", 0, 0, 0);
        #1 rst = 1'b0;
        apply(1, 1, 8'hFF);
        expect3("rr_after_rst", 7, 1, 1);

        // Fixed walking one.
        for (int i = 0; i < N; i++) begin
            one = 8'h01 << i;
            apply(1, 0, one);
            expect3("walk", i, 1, 0);
        end

        apply(1, 0, 8'b1010_0110);
        expect3("fixed_multi", 7, 1, 1);
        apply(1, 0, 8'h00);
        expect3("fixed_zero", 0, 0, 0);

        // Round-robin fairness with all requests held.
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            apply(1, 1, 8'hFF);
            expect3("rr_fair", seq[i], 1, 1);
        end

        // Round-robin wrap and skip.
        pulse_reset();
        apply(1, 1, 8'h04); expect3("rr_w1", 2, 1, 0);
        apply(1, 1, 8'h84); expect3("rr_w2", 7, 1, 1);
        apply(1, 1, 8'h84); expect3("rr_w3", 2, 1, 1);
        apply(1, 1, 8'h00); expect3("rr_w4", 0, 0, 0);
        apply(1, 1, 8'h03); expect3("rr_w5", 1, 1, 1);

        // Enable hold with ptr=4, then mode switching.
        pulse_reset();
        apply(1, 1, 8'h20); expect3("hold_setup", 5, 1, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, $urandom_range(0, 1), 8'($urandom));
            expect3("hold", 5, 1, 0);
        end
        apply(1, 1, 8'h30); expect3("hold_ptr", 4, 1, 1);
        apply(1, 0, 8'h11); expect3("sw_fixed", 4, 1, 1);
        apply(1, 1, 8'h11); expect3("sw_rr", 4, 1, 1);

        // Randomized run; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] d;
            case ($urandom_range(0, 3))
                0:       d = '0;
                1:       d = 8'h01 << $urandom_range(0, N - 1);
                default: d = 8'($urandom);
            endcase
            apply($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, d);
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end

        check_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
